// File: rtl/op_queue.sv
// Circular-buffer operation queue: registered pop data with a one-cycle valid strobe,
// combinational full/empty from the occupancy count, and sticky over/underflow flags.
module op_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             flush,
  input  logic             wrEn,
  input  logic [WIDTH-1:0] opWrite,
  input  logic             rdEn,
  input  logic             clrErr,
  output logic [WIDTH-1:0] opBus,
  output logic             opValid,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_bus;
  logic             r_vld, r_ovf, r_udf;

  logic w_full, w_empty, w_rd_acc, w_wr_acc, w_ovf_set, w_udf_set;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);

  // A read frees a slot in the same cycle, so a full queue still takes a write alongside it.
  assign w_rd_acc  = rdEn & ~w_empty & ~flush;
  assign w_wr_acc  = wrEn & ~flush & (~w_full | w_rd_acc);
  assign w_udf_set = rdEn & ~flush & w_empty;
  assign w_ovf_set = wrEn & ~flush & ~w_wr_acc;

  // Storage carries no reset; pointers and count alone define which slots are live.
  always_ff @(posedge clk) begin
    if (w_wr_acc && nReset) r_mem[r_wptr] <= opWrite;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_bus   <= '0;
      r_vld   <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_vld <= w_rd_acc;
      if (flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
        if (w_rd_acc) begin
          r_rptr <= r_rptr + AW'(1);
          r_bus  <= r_mem[r_rptr];
        end
        case ({w_wr_acc, w_rd_acc})
          2'b10:   r_count <= r_count + (AW+1)'(1);
          2'b01:   r_count <= r_count - (AW+1)'(1);
          default: r_count <= r_count;
        endcase
      end
      // A fresh error in the clearing cycle keeps its flag set.
      r_ovf <= w_ovf_set | (r_ovf & ~clrErr);
      r_udf <= w_udf_set | (r_udf & ~clrErr);
    end
  end

  assign opBus     = r_bus;
  assign opValid   = r_vld;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign overflow  = r_ovf;
  assign underflow = r_udf;

endmodule
